alu_wide_sequencer: RTL and testbench

//  Runs one wide (W*N-bit) arithmetic/logic op as N back-to-back W-bit micro-ops on the shared ALU.

---
 rtl/alu_wide_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_wide_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// Wide ALU op sequencer: splits one W*N-bit op into N W-bit micro-ops on a
// shared ALU, chaining carry LSW first, and returns the wide result.
module alu_wide_sequencer #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_op,
  input  logic [W*N-1:0] req_a,
  input  logic [W*N-1:0] req_b,
  output logic [2:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W*N-1:0] rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic           busy
);
  // Op codes shared by request and ALU side; 001 (add-with-carry) and 110
  // are not legal as wide requests.
  localparam logic [2:0] K_ADD  = 3'b000;
  localparam logic [2:0] K_ADDC = 3'b001;
  localparam logic [2:0] K_SUB  = 3'b010;
  localparam logic [2:0] K_SLL  = 3'b011;
  localparam logic [2:0] K_OR   = 3'b100;
  localparam logic [2:0] K_NEG  = 3'b101;
  localparam logic [2:0] K_AND  = 3'b111;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W*N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0]  k_q, k_d;
  logic           c_q, c_d, err_q, err_d;
  logic [W-1:0]   aw, bw;
  logic           first, last, legal;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= K_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Next state, micro-op issue and per-word result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    c_d     = c_q;
    err_d   = err_q;
    alu_op  = K_ADD;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    aw      = a_q[k_q*W +: W];
    bw      = b_q[k_q*W +: W];
    first   = (k_q == '0);
    last    = (k_q == KW'(N-1));
    legal   = (req_op != K_ADDC) && (req_op != 3'b110);
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          k_d   = '0;
          c_d   = 1'b0;
          res_d = '0;
          err_d = !legal;
          state_d = legal ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Arithmetic ops: first word uses the plain op, later words chain carry
        case (op_q)
          K_ADD: begin
            alu_op = first ? K_ADD : K_ADDC;
            alu_a  = aw;
            alu_b  = bw;
          end
          K_SUB: begin
            alu_op = first ? K_SUB : K_ADDC;
            alu_a  = aw;
            alu_b  = first ? bw : ~bw;
          end
          K_SLL: begin
            alu_op = first ? K_ADD : K_ADDC;
            alu_a  = aw;
            alu_b  = aw;
          end
          K_NEG: begin
            alu_op = first ? K_SUB : K_ADDC;
            alu_a  = '0;
            alu_b  = first ? aw : ~aw;
          end
          K_AND: begin
            alu_op = K_AND;
            alu_a  = aw;
            alu_b  = bw;
          end
          default: begin
            alu_op = K_OR;
            alu_a  = aw;
            alu_b  = bw;
          end
        endcase
        if (alu_op == K_ADDC) alu_cin = c_q;
        res_d[k_q*W +: W] = alu_result;
        c_d = (op_q == K_AND || op_q == K_OR) ? 1'b0 : alu_cout;
        k_d = k_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response is only presented in DONE; zeros otherwise
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q == S_RUN);
    rsp_valid  = (state_q == S_DONE);
    rsp_result = rsp_valid ? res_q : '0;
    rsp_carry  = rsp_valid & c_q;
    rsp_err    = rsp_valid & err_q;
  end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench: directed spec cases plus random ops against a
// whole-word arithmetic reference, with a behavioural W-bit ALU attached.
module tb_alu_wide_sequencer;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int WN = W*N;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, alu_cin, alu_cout;
  logic [2:0]    req_op, alu_op;
  logic [WN-1:0] req_a, req_b, rsp_result;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic          rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;

  int vecs = 0;
  int errs = 0;

  alu_wide_sequencer #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_result(alu_result),
    .alu_cout(alu_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural W-bit ALU
  always_comb begin
    logic [W:0] s;
    s = '0;
    case (alu_op)
      3'b000: s = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: s = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      3'b010: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
      3'b100: s = {1'b0, alu_a | alu_b};
      3'b111: s = {1'b0, alu_a & alu_b};
      default: s = '0;
    endcase
    alu_result = s[W-1:0];
    alu_cout   = s[W];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-operand reference
  task automatic ref_model(input logic [2:0] op, input logic [WN-1:0] a, input logic [WN-1:0] b,
                           output logic [WN-1:0] res, output logic cy, output logic er);
    logic [WN:0] s;
    res = '0; cy = 1'b0; er = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; res = s[WN-1:0]; cy = s[WN]; end
      3'b010: begin res = a - b; cy = (a >= b); end
      3'b011: begin res = a << 1; cy = a[WN-1]; end
      3'b101: begin res = -a; cy = (a == '0); end
      3'b100: res = a | b;
      3'b111: res = a & b;
      default: er = 1'b1;
    endcase
  endtask

  // One transaction: drive request, check latency/ALU ops, backpressure for
  // `hold` cycles with a competing req_valid, then release.
  task automatic run_op(input logic [2:0] op, input logic [WN-1:0] a, input logic [WN-1:0] b,
                        input int hold);
    logic [WN-1:0] eres;
    logic ecy, eer;
    logic [2:0] ops[$];
    logic [WN-1:0] r0;
    logic c0, e0;
    int n;
    ref_model(op, a, b, eres, ecy, eer);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = WN'($urandom); req_b = WN'($urandom); req_op = 3'($urandom);
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (busy) ops.push_back(alu_op);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", n, eer ? 0 : N);
    chk("uops", ops.size(), eer ? 0 : N);
    if (!eer && ops.size() == N) begin
      chk("uop0", ops[0], (op == 3'b010 || op == 3'b101) ? 3'b010 :
                          (op == 3'b000 || op == 3'b011) ? 3'b000 : op);
      chk("uop1", ops[1], (op == 3'b100 || op == 3'b111) ? op : 3'b001);
    end
    chk("result", rsp_result, eres);
    chk("carry", rsp_carry, ecy);
    chk("err", rsp_err, eer);
    chk("busy_done", busy, 1'b0);
    r0 = rsp_result; c0 = rsp_carry; e0 = rsp_err;
    if (hold > 0) begin
      req_valid = 1'b1; req_op = 3'b000;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_stable", {rsp_result, rsp_carry, rsp_err}, {r0, c0, e0});
        chk("hold_rdy", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_ready", req_ready, 1'b1);
    chk("post_valid", rsp_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_carry, rsp_err, busy}, 4'b0);
    chk("rst_res", rsp_result, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    reset = 1'b0;

    run_op(3'b000, 16'h00FF, 16'h0001, 0);
    run_op(3'b010, 16'h0100, 16'h0001, 0);
    run_op(3'b010, 16'h0000, 16'h0001, 0);
    run_op(3'b011, 16'h8081, 16'h1234, 0);
    run_op(3'b101, 16'h0001, 16'h0000, 0);
    run_op(3'b101, 16'h0000, 16'hFFFF, 0);
    run_op(3'b111, 16'hF0F0, 16'h0FF0, 0);
    run_op(3'b100, 16'hF0F0, 16'h0FF0, 0);
    run_op(3'b000, 16'hFFFF, 16'h0001, 5);
    run_op(3'b001, 16'h1234, 16'h5678, 0);
    run_op(3'b110, 16'h1234, 16'h5678, 2);

    // Reset during RUN at word 1
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b000; req_a = 16'h1111; req_b = 16'h2222; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_k1_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_rsp", {rsp_valid, rsp_carry, rsp_err, busy}, 4'b0);
    chk("abort_alu", {alu_op, alu_a, alu_b, alu_cin}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_norsp", rsp_valid, 1'b0);
    end

    for (int t = 0; t < 80; t++)
      run_op(3'($urandom), WN'($urandom), WN'($urandom), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
